// File: rtl/rtc_pkg.sv
// Shared types and helpers for the BCD real-time-clock slice.
//   bcd_digit_t / bcd_pair_t : one BCD digit / two packed BCD digits (tens[7:4], units[3:0])
//   BCD_MAX_MS / BCD_MAX_H   : upper limits for minutes/seconds and 24h hours
//   bcd_valid(pair, max)     : both digits <= 9 and pair <= max
//   to_12h(pair)             : 24h BCD hour -> {pm, 12h BCD hour}
package rtc_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd_pair_t;

    localparam bcd_pair_t BCD_MAX_MS = 8'h59;
    localparam bcd_pair_t BCD_MAX_H  = 8'h23;

    // With both digits <= 9 a plain binary compare orders BCD values correctly.
    function automatic logic bcd_valid(input bcd_pair_t pair, input bcd_pair_t max);
        return (pair[7:4] <= 4'd9) && (pair[3:0] <= 4'd9) && (pair <= max);
    endfunction

    function automatic logic [8:0] to_12h(input bcd_pair_t pair);
        logic [8:0] r;
        case (pair)
            8'h00:   r = {1'b0, 8'h12};
            8'h12:   r = {1'b1, 8'h12};
            8'h13:   r = {1'b1, 8'h01};
            8'h14:   r = {1'b1, 8'h02};
            8'h15:   r = {1'b1, 8'h03};
            8'h16:   r = {1'b1, 8'h04};
            8'h17:   r = {1'b1, 8'h05};
            8'h18:   r = {1'b1, 8'h06};
            8'h19:   r = {1'b1, 8'h07};
            8'h20:   r = {1'b1, 8'h08};
            8'h21:   r = {1'b1, 8'h09};
            8'h22:   r = {1'b1, 8'h10};
            8'h23:   r = {1'b1, 8'h11};
            default: r = {1'b0, pair};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (0 .. MAX, wraps to 00).
//   clk, resetn : clock, asynchronous active-low reset (value -> 00)
//   inc         : advance by one this edge
//   load        : write load_val this edge (has priority over inc)
//   load_val    : BCD value to load
//   value       : current BCD value
//   next_value  : value after this edge if inc applies (combinational look-ahead)
//   carry_out   : inc while at MAX, i.e. the counter wraps this edge
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter bcd_pair_t MAX = 8'h59
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      inc,
    input  logic      load,
    input  bcd_pair_t load_val,
    output bcd_pair_t value,
    output bcd_pair_t next_value,
    output logic      carry_out
);

    always_comb begin
        next_value = value;
        carry_out  = 1'b0;
        if (inc) begin
            if (value == MAX) begin
                next_value = '0;
                carry_out  = 1'b1;
            end else if (value[3:0] == 4'd9) begin
                next_value = {value[7:4] + 4'd1, 4'd0};
            end else begin
                next_value = {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/rtc_bcd_timekeeper.sv
// Time-of-day counter: prescales clk to a 1 s tick, keeps HH:MM:SS in BCD (24h internally),
// accepts validated loads, presents 12h or 24h hours and raises a one-shot HH:MM alarm.
//   clk, resetn                  : clock, asynchronous active-low reset
//   run                          : prescaler advances when 1
//   load_valid, load_h/m/s       : set request (24h BCD), checked for BCD range
//   alarm_en, alarm_h, alarm_m   : alarm arm and 24h BCD alarm time
//   h, m, s, pm                  : displayed time (h per FMT_12H), pm = hour >= 12
//   sec_tick, load_ack, load_err, alarm_pulse : one-cycle event pulses
module rtc_bcd_timekeeper
    import rtc_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter bit          FMT_12H       = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       run,
    input  logic       load_valid,
    input  logic [7:0] load_h,
    input  logic [7:0] load_m,
    input  logic [7:0] load_s,
    input  logic       alarm_en,
    input  logic [7:0] alarm_h,
    input  logic [7:0] alarm_m,
    output logic [7:0] h,
    output logic [7:0] m,
    output logic [7:0] s,
    output logic       pm,
    output logic       sec_tick,
    output logic       load_ack,
    output logic       load_err,
    output logic       alarm_pulse
);

    localparam int unsigned PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;
    logic          term;
    logic          load_ok;
    logic          load_bad;
    logic          tick;
    logic          alarm_hit;
    bcd_pair_t     sec_val, min_val, hr_val;
    bcd_pair_t     sec_nxt, min_nxt, hr_nxt;
    logic          sec_carry, min_carry;
    logic [8:0]    hr_12;

    assign term     = run && (presc == TERM);
    assign load_ok  = load_valid && bcd_valid(load_h, BCD_MAX_H)
                      && bcd_valid(load_m, BCD_MAX_MS) && bcd_valid(load_s, BCD_MAX_MS);
    assign load_bad = load_valid && !load_ok;
    // An accepted load replaces the time outright, so a coincident tick is dropped.
    assign tick     = term && !load_ok;

    // Compare against the look-ahead time so the pulse lands on the same edge as the tick.
    assign alarm_hit = tick && alarm_en
                       && bcd_valid(alarm_h, BCD_MAX_H) && bcd_valid(alarm_m, BCD_MAX_MS)
                       && (sec_nxt == 8'h00) && (min_nxt == alarm_m) && (hr_nxt == alarm_h);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc <= '0;
        end else if (load_ok) begin
            presc <= '0;
        end else if (run) begin
            presc <= term ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sec_tick    <= 1'b0;
            load_ack    <= 1'b0;
            load_err    <= 1'b0;
            alarm_pulse <= 1'b0;
        end else begin
            sec_tick    <= tick;
            load_ack    <= load_ok;
            load_err    <= load_bad;
            alarm_pulse <= alarm_hit;
        end
    end

    bcd_mod_counter #(.MAX(BCD_MAX_MS)) u_sec (
        .clk        (clk),
        .resetn     (resetn),
        .inc        (tick),
        .load       (load_ok),
        .load_val   (load_s),
        .value      (sec_val),
        .next_value (sec_nxt),
        .carry_out  (sec_carry)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_MS)) u_min (
        .clk        (clk),
        .resetn     (resetn),
        .inc        (sec_carry),
        .load       (load_ok),
        .load_val   (load_m),
        .value      (min_val),
        .next_value (min_nxt),
        .carry_out  (min_carry)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_H)) u_hr (
        .clk        (clk),
        .resetn     (resetn),
        .inc        (min_carry),
        .load       (load_ok),
        .load_val   (load_h),
        .value      (hr_val),
        .next_value (hr_nxt),
        .carry_out  ()
    );

    assign hr_12 = to_12h(hr_val);
    assign h     = FMT_12H ? hr_12[7:0] : hr_val;
    assign m     = min_val;
    assign s     = sec_val;
    assign pm    = (hr_val >= 8'h12);

endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// Scoreboard bench: two instances (24h and 12h, TICKS_PER_SEC=4) share one stimulus stream.
// Stimulus pushes the expected event records; a negedge monitor pops one record per output
// event and compares both instances against it.
module tb_rtc_bcd_timekeeper;

    typedef struct packed {
        logic       tick;
        logic       ack;
        logic       err;
        logic       alarm;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic       pm;
    } obs_t;

    typedef struct packed {
        obs_t       o;
        logic [7:0] h12;
    } exp_t;

    logic       clk;
    logic       resetn;
    logic       run;
    logic       load_valid;
    logic [7:0] load_h, load_m, load_s;
    logic       alarm_en;
    logic [7:0] alarm_h, alarm_m;

    logic [7:0] h24, m24, s24;
    logic       pm24, tick24, ack24, err24, al24;
    logic [7:0] h12, m12, s12;
    logic       pm12, tick12, ack12, err12, al12;

    int tests = 0;
    int fails = 0;
    int nev   = 0;
    exp_t sb[$];

    rtc_bcd_timekeeper #(.TICKS_PER_SEC(4), .FMT_12H(1'b0)) u_dut24 (
        .clk(clk), .resetn(resetn), .run(run), .load_valid(load_valid),
        .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .alarm_en(alarm_en), .alarm_h(alarm_h), .alarm_m(alarm_m),
        .h(h24), .m(m24), .s(s24), .pm(pm24),
        .sec_tick(tick24), .load_ack(ack24), .load_err(err24), .alarm_pulse(al24)
    );

    rtc_bcd_timekeeper #(.TICKS_PER_SEC(4), .FMT_12H(1'b1)) u_dut12 (
        .clk(clk), .resetn(resetn), .run(run), .load_valid(load_valid),
        .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .alarm_en(alarm_en), .alarm_h(alarm_h), .alarm_m(alarm_m),
        .h(h12), .m(m12), .s(s12), .pm(pm12),
        .sec_tick(tick12), .load_ack(ack12), .load_err(err12), .alarm_pulse(al12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle with any event pulse consumes one expected record.
    always @(negedge clk) begin : monitor
        obs_t a24, a12, e24, e12;
        exp_t x;
        if (resetn && (tick24 | ack24 | err24 | al24 | tick12 | ack12 | err12 | al12)) begin
            nev++;
            a24 = '{tick24, ack24, err24, al24, h24, m24, s24, pm24};
            a12 = '{tick12, ack12, err12, al12, h12, m12, s12, pm12};
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event%0d: got 24h %h / 12h %h, expected no event", nev, a24, a12);
            end else begin
                x = sb.pop_front();
                e24 = x.o;
                e12 = x.o;
                e12.h = x.h12;
                tests++;
                if (a24 !== e24) begin
                    fails++;
                    $display("FAIL event%0d_24h: got %h expected %h", nev, a24, e24);
                end
                tests++;
                if (a12 !== e12) begin
                    fails++;
                    $display("FAIL event%0d_12h: got %h expected %h", nev, a12, e12);
                end
            end
        end
    end

    task automatic push(input logic t, input logic a, input logic e, input logic al,
                        input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                        input logic p, input logic [7:0] hh12);
        exp_t x;
        x.o.tick  = t;
        x.o.ack   = a;
        x.o.err   = e;
        x.o.alarm = al;
        x.o.h     = hh;
        x.o.m     = mm;
        x.o.s     = ss;
        x.o.pm    = p;
        x.h12     = hh12;
        sb.push_back(x);
    endtask

    task automatic run_cycles(input int n);
        run = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        run = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                           input logic r);
        load_h = hh;
        load_m = mm;
        load_s = ss;
        load_valid = 1'b1;
        run = r;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        run = 1'b0;
    endtask

    // Waits past the monitor's sampling point, then checks how many events are still owed.
    task automatic expect_pending(input int n, input string name);
        @(negedge clk);
        #1;
        tests++;
        if (sb.size() != n) begin
            fails++;
            $display("FAIL pending_%s: got %0d queued, expected %0d", name, sb.size(), n);
        end
    endtask

    task automatic check_reset(input string name);
        tests++;
        if ({h24, m24, s24, pm24, tick24, ack24, err24, al24} !== {8'h00, 8'h00, 8'h00, 5'b0}) begin
            fails++;
            $display("FAIL reset24_%s: got %h:%h:%h pm=%b pulses=%b%b%b%b expected 00:00:00 pm=0 pulses=0000",
                     name, h24, m24, s24, pm24, tick24, ack24, err24, al24);
        end
        tests++;
        if ({h12, m12, s12, pm12, tick12, ack12, err12, al12} !== {8'h12, 8'h00, 8'h00, 5'b0}) begin
            fails++;
            $display("FAIL reset12_%s: got %h:%h:%h pm=%b pulses=%b%b%b%b expected 12:00:00 pm=0 pulses=0000",
                     name, h12, m12, s12, pm12, tick12, ack12, err12, al12);
        end
    endtask

    initial begin
        resetn = 1'b0;
        run = 1'b0;
        load_valid = 1'b0;
        load_h = 8'h00;
        load_m = 8'h00;
        load_s = 8'h00;
        alarm_en = 1'b0;
        alarm_h = 8'h07;
        alarm_m = 8'h30;

        repeat (2) @(posedge clk);
        #1;
        check_reset("initial");
        @(negedge clk);
        resetn = 1'b1;

        // Free-running from reset: tick on every 4th enabled edge.
        push(1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 8'h12);
        push(1, 0, 0, 0, 8'h00, 8'h00, 8'h02, 0, 8'h12);
        run_cycles(3);
        expect_pending(2, "first3");
        run_cycles(1);
        expect_pending(1, "first4");
        run_cycles(4);
        expect_pending(0, "first8");

        // Day wrap through 23:59:59.
        push(0, 1, 0, 0, 8'h23, 8'h59, 8'h58, 1, 8'h11);
        do_load(8'h23, 8'h59, 8'h58, 1'b0);
        push(1, 0, 0, 0, 8'h23, 8'h59, 8'h59, 1, 8'h11);
        push(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h12);
        run_cycles(8);
        expect_pending(0, "daywrap");

        // Accepted load clears a part-way prescaler.
        run_cycles(2);
        push(0, 1, 0, 0, 8'h01, 8'h02, 8'h03, 0, 8'h01);
        do_load(8'h01, 8'h02, 8'h03, 1'b0);
        push(1, 0, 0, 0, 8'h01, 8'h02, 8'h04, 0, 8'h01);
        run_cycles(3);
        expect_pending(1, "presc_clear3");
        run_cycles(1);
        expect_pending(0, "presc_clear4");

        // Rejected loads leave time alone.
        push(0, 0, 1, 0, 8'h01, 8'h02, 8'h04, 0, 8'h01);
        do_load(8'h24, 8'h00, 8'h00, 1'b0);
        push(0, 0, 1, 0, 8'h01, 8'h02, 8'h04, 0, 8'h01);
        do_load(8'h10, 8'h5A, 8'h00, 1'b0);
        push(0, 0, 1, 0, 8'h01, 8'h02, 8'h04, 0, 8'h01);
        do_load(8'h1A, 8'h00, 8'h00, 1'b0);
        push(0, 0, 1, 0, 8'h01, 8'h02, 8'h04, 0, 8'h01);
        do_load(8'h00, 8'h00, 8'h60, 1'b0);
        expect_pending(0, "bad_loads");

        // Accepted load on the terminal-count edge: tick discarded, prescaler restarts.
        run_cycles(3);
        push(0, 1, 0, 0, 8'h05, 8'h06, 8'h07, 0, 8'h05);
        do_load(8'h05, 8'h06, 8'h07, 1'b1);
        push(1, 0, 0, 0, 8'h05, 8'h06, 8'h08, 0, 8'h05);
        run_cycles(3);
        expect_pending(1, "coincide_ok3");
        run_cycles(1);
        expect_pending(0, "coincide_ok4");

        // Rejected load on the terminal-count edge: tick still happens.
        run_cycles(3);
        push(1, 0, 1, 0, 8'h05, 8'h06, 8'h09, 0, 8'h05);
        do_load(8'h25, 8'h00, 8'h00, 1'b1);
        expect_pending(0, "coincide_bad");

        // Alarm 07:30 armed.
        alarm_en = 1'b1;
        push(0, 1, 0, 0, 8'h07, 8'h29, 8'h59, 0, 8'h07);
        do_load(8'h07, 8'h29, 8'h59, 1'b0);
        push(1, 0, 0, 1, 8'h07, 8'h30, 8'h00, 0, 8'h07);
        run_cycles(4);
        push(0, 1, 0, 0, 8'h07, 8'h30, 8'h00, 0, 8'h07);
        do_load(8'h07, 8'h30, 8'h00, 1'b0);
        push(1, 0, 0, 0, 8'h07, 8'h30, 8'h01, 0, 8'h07);
        run_cycles(4);
        expect_pending(0, "alarm_armed");

        // Alarm disarmed.
        alarm_en = 1'b0;
        push(0, 1, 0, 0, 8'h07, 8'h29, 8'h59, 0, 8'h07);
        do_load(8'h07, 8'h29, 8'h59, 1'b0);
        push(1, 0, 0, 0, 8'h07, 8'h30, 8'h00, 0, 8'h07);
        run_cycles(4);
        expect_pending(0, "alarm_off");

        // 12h presentation.
        push(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h12);
        do_load(8'h00, 8'h00, 8'h00, 1'b0);
        push(0, 1, 0, 0, 8'h13, 8'h05, 8'h00, 1, 8'h01);
        do_load(8'h13, 8'h05, 8'h00, 1'b0);
        push(0, 1, 0, 0, 8'h12, 8'h00, 8'h00, 1, 8'h12);
        do_load(8'h12, 8'h00, 8'h00, 1'b0);
        push(0, 1, 0, 0, 8'h11, 8'h59, 8'h59, 0, 8'h11);
        do_load(8'h11, 8'h59, 8'h59, 1'b0);
        push(1, 0, 0, 0, 8'h12, 8'h00, 8'h00, 1, 8'h12);
        run_cycles(4);
        expect_pending(0, "fmt12");

        // Asynchronous reset mid-count with a load pending.
        run_cycles(2);
        load_h = 8'h09;
        load_m = 8'h08;
        load_s = 8'h07;
        load_valid = 1'b1;
        run = 1'b1;
        #2;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_reset("midop");
        load_valid = 1'b0;
        run = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        push(1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 8'h12);
        run_cycles(3);
        expect_pending(1, "after_reset3");
        run_cycles(1);
        expect_pending(0, "after_reset4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
